// File: rtl/ecc_kp_requester.sv
`timescale 1ns/1ps
// Host-side requester for the ECC kP core: checks operands, pulses the core start,
// waits for done under a timeout and returns the point with a status code.
module ecc_kp_requester #(
    parameter int W       = 4,
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_prime,
    input  logic [W-1:0] req_px,
    input  logic [W-1:0] req_py,
    input  logic [W-1:0] req_k,
    output logic         core_start,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_prime,
    output logic [W-1:0] core_px,
    output logic [W-1:0] core_py,
    output logic [W-1:0] core_k,
    input  logic [W-1:0] core_kpx,
    input  logic [W-1:0] core_kpy,
    input  logic         core_done,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_kpx,
    output logic [W-1:0] res_kpy,
    output logic [1:0]   res_status,
    output logic         busy
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_ARM, S_WAIT, S_RESP} state_t;

    localparam logic [1:0]    ST_OK  = 2'b00;
    localparam logic [1:0]    ST_INF = 2'b01;
    localparam logic [1:0]    ST_TMO = 2'b10;
    localparam logic [1:0]    ST_BAD = 2'b11;
    localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           req_ready_q, core_start_q, res_valid_q, busy_q;
    logic [W-1:0]   a_q, prime_q, px_q, py_q, k_q;
    logic [W-1:0]   kpx_q, kpy_q;
    logic [1:0]     status_q;

    logic bad_op, k_zero, tmo_hit;

    always_comb begin
        bad_op  = (req_prime < W'(2)) || (req_px >= req_prime) || (req_py >= req_prime);
        k_zero  = (req_k == '0);
        tmo_hit = (cnt_q >= TMO);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            core_start_q <= 1'b0;
            res_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            a_q          <= '0;
            prime_q      <= '0;
            px_q         <= '0;
            py_q         <= '0;
            k_q          <= '0;
            kpx_q        <= '0;
            kpy_q        <= '0;
            status_q     <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        a_q         <= req_a;
                        prime_q     <= req_prime;
                        px_q        <= req_px;
                        py_q        <= req_py;
                        k_q         <= req_k;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        // Operand errors outrank k==0; neither case ever starts the core.
                        if (bad_op || k_zero) begin
                            kpx_q       <= '0;
                            kpy_q       <= '0;
                            status_q    <= bad_op ? ST_BAD : ST_INF;
                            res_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            core_start_q <= 1'b1;
                            state_q      <= S_START;
                        end
                    end
                end
                S_START: begin
                    core_start_q <= 1'b0;
                    cnt_q        <= '0;
                    state_q      <= S_ARM;
                end
                S_ARM, S_WAIT: begin
                    if (!tmo_hit) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // ARM drains a done left high by the previous operation; done wins over timeout.
                    if (state_q == S_ARM && !core_done) begin
                        state_q <= S_WAIT;
                    end else if (state_q == S_WAIT && core_done) begin
                        kpx_q       <= core_kpx;
                        kpy_q       <= core_kpy;
                        status_q    <= ST_OK;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (tmo_hit) begin
                        kpx_q       <= '0;
                        kpy_q       <= '0;
                        status_q    <= ST_TMO;
                        res_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign core_start = core_start_q;
    assign core_a     = a_q;
    assign core_prime = prime_q;
    assign core_px    = px_q;
    assign core_py    = py_q;
    assign core_k     = k_q;
    assign res_valid  = res_valid_q;
    assign res_kpx    = kpx_q;
    assign res_kpy    = kpy_q;
    assign res_status = status_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ecc_kp_requester.sv
`timescale 1ns/1ps
// Scoreboard bench for ecc_kp_requester with a behavioural ECC core stand-in.
module tb_ecc_kp_requester;

    localparam int W = 4;
    localparam int T = 20;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready;
    logic [W-1:0] req_a, req_prime, req_px, req_py, req_k;
    logic core_start;
    logic [W-1:0] core_a, core_prime, core_px, core_py, core_k;
    logic [W-1:0] core_kpx, core_kpy;
    logic core_done;
    logic res_valid, res_ready;
    logic [W-1:0] res_kpx, res_kpy;
    logic [1:0] res_status;
    logic busy;

    ecc_kp_requester #(.W(W), .TIMEOUT(T), .CW(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_prime(req_prime), .req_px(req_px), .req_py(req_py), .req_k(req_k),
        .core_start(core_start),
        .core_a(core_a), .core_prime(core_prime), .core_px(core_px), .core_py(core_py), .core_k(core_k),
        .core_kpx(core_kpx), .core_kpy(core_kpy), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_kpx(res_kpx), .res_kpy(res_kpy), .res_status(res_status),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int x, y, st, nstart, lat;
        int a, p, px, py, k;
    } exp_t;
    exp_t sbq[$];

    // Core stand-in: done forced high for rel<drop, low until rel>=rise, then high with result
    int cfg_drop = 0, cfg_rise = -1, cfg_x = 0, cfg_y = 0;
    int start_cyc = -1;
    int starts = 0;
    int rel;

    always @(negedge clk) begin
        if (rst) start_cyc = -1;
        else if (core_start) begin
            start_cyc = cyc;
            starts++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst || start_cyc < 0) begin
            core_done = 1'b0;
            core_kpx  = W'($urandom);
            core_kpy  = W'($urandom);
        end else begin
            rel = cyc - start_cyc;
            if (rel < cfg_drop) begin
                core_done = 1'b1;
                core_kpx  = W'($urandom);
                core_kpy  = W'($urandom);
            end else if (cfg_rise >= 0 && rel >= cfg_rise) begin
                core_done = 1'b1;
                core_kpx  = W'(cfg_x);
                core_kpy  = W'(cfg_y);
            end else begin
                core_done = 1'b0;
                core_kpx  = W'($urandom);
                core_kpy  = W'($urandom);
            end
        end
    end

    int hold_req = 0;
    int hold = 0;
    always @(posedge clk) begin
        #1;
        if (hold_req > 0) begin
            hold = hold_req;
            hold_req = 0;
        end
        if (hold > 0) begin
            hold--;
            res_ready = 1'b0;
        end else begin
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor
    logic prev_rv = 1'b0, prev_rr = 1'b0;
    logic [W-1:0] prev_x, prev_y;
    logic [1:0] prev_st;
    int acc_cyc = -1, acc_starts = 0, rv_cyc = -1;
    bit inflight = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (rst) begin
            inflight = 1'b0;
            prev_rv  = 1'b0;
        end else begin
            check("busy", int'(busy), int'(inflight));
            check("req_ready", int'(req_ready), int'(!inflight));
            if (res_valid && !prev_rv) begin
                rv_cyc = cyc;
                if (sbq.size() == 0) check("unexpected_res_valid", 1, 0);
            end
            if (prev_rv && !prev_rr) begin
                check("hold_valid", int'(res_valid), 1);
                check("hold_kpx", int'(res_kpx), int'(prev_x));
                check("hold_kpy", int'(res_kpy), int'(prev_y));
                check("hold_status", int'(res_status), int'(prev_st));
            end
            if (res_valid && res_ready && sbq.size() > 0) begin
                e = sbq.pop_front();
                check("res_kpx", int'(res_kpx), e.x);
                check("res_kpy", int'(res_kpy), e.y);
                check("res_status", int'(res_status), e.st);
                check("start_count", starts - acc_starts, e.nstart);
                if (e.nstart > 0) begin
                    check("start_after_accept", start_cyc - acc_cyc, 1);
                    check("latency_from_start", rv_cyc - start_cyc, e.lat);
                end else begin
                    check("latency_from_accept", rv_cyc - acc_cyc, e.lat);
                end
                check("core_a", int'(core_a), e.a);
                check("core_prime", int'(core_prime), e.p);
                check("core_px", int'(core_px), e.px);
                check("core_py", int'(core_py), e.py);
                check("core_k", int'(core_k), e.k);
            end
            if (req_valid && req_ready) begin
                acc_cyc    = cyc;
                acc_starts = starts;
                inflight   = 1'b1;
            end
            if (res_valid && res_ready) inflight = 1'b0;
            prev_rv = res_valid;
            prev_rr = res_ready;
            prev_x  = res_kpx;
            prev_y  = res_kpy;
            prev_st = res_status;
        end
    end

    // Reference: status from operand rules; latency from the core's done waveform.
    task automatic do_req(input int a, input int p, input int px, input int py, input int k,
                          input int drop, input int rise, input int rx, input int ry);
        exp_t ex;
        int guard;
        int arm_exit;
        guard = 0;
        while (!req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("wait_idle_timeout", 0, 1);
                return;
            end
        end
        ex.a = a; ex.p = p; ex.px = px; ex.py = py; ex.k = k;
        if (p < 2 || px >= p || py >= p) begin
            ex.st = 3; ex.x = 0; ex.y = 0; ex.nstart = 0; ex.lat = 1;
        end else if (k == 0) begin
            ex.st = 1; ex.x = 0; ex.y = 0; ex.nstart = 0; ex.lat = 1;
        end else if (rise < 0) begin
            ex.st = 2; ex.x = 0; ex.y = 0; ex.nstart = 1; ex.lat = T + 2;
        end else begin
            arm_exit = (drop > 1) ? drop : 1;
            ex.st = 0; ex.x = rx; ex.y = ry; ex.nstart = 1;
            ex.lat = ((arm_exit + 1 > rise) ? arm_exit + 1 : rise) + 1;
        end
        sbq.push_back(ex);
        cfg_drop = drop; cfg_rise = rise; cfg_x = rx; cfg_y = ry;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_a = W'(a); req_prime = W'(p); req_px = W'(px); req_py = W'(py); req_k = W'(k);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = W'($urandom); req_prime = W'($urandom);
        req_px = W'($urandom); req_py = W'($urandom); req_k = W'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (sbq.size() != 0 || !req_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 300) begin
                check("drain_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, px, py, k, drop, rise, s0, seen;
        rst = 1'b1;
        req_valid = 1'b0;
        req_a = '0; req_prime = '0; req_px = '0; req_py = '0; req_k = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_core_start", int'(core_start), 0);
        check("rst_res_status", int'(res_status), 0);
        check("rst_res_kpx", int'(res_kpx), 0);
        check("rst_core_k", int'(core_k), 0);
        rst = 1'b0;
        @(negedge clk);

        do_req(2, 11, 2, 7, 3, 0, 10, 8, 3);
        do_req(2, 11, 2, 7, 0, 0, 10, 1, 1);
        do_req(2, 11, 12, 7, 3, 0, 10, 1, 1);
        do_req(2, 1, 0, 0, 3, 0, 10, 1, 1);
        do_req(2, 11, 12, 7, 0, 0, 10, 1, 1);
        do_req(2, 11, 2, 7, 3, 0, -1, 0, 0);
        do_req(3, 13, 5, 6, 9, 0, 6, 4, 1);
        do_req(2, 11, 2, 7, 5, 3, 7, 9, 2);
        hold_req = 7;
        do_req(1, 11, 12, 3, 4, 0, 5, 1, 1);
        wait_drain();

        for (int i = 0; i < 30; i++) begin
            p  = $urandom_range(0, 15);
            px = $urandom_range(0, 15);
            py = $urandom_range(0, 15);
            if (p >= 2 && $urandom_range(0, 3) != 0) begin
                px = $urandom_range(0, p - 1);
                py = $urandom_range(0, p - 1);
            end
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) k = 0;
            drop = $urandom_range(0, 4);
            if ($urandom_range(0, 5) == 0) rise = -1;
            else rise = ((drop > 1) ? drop : 1) + 1 + $urandom_range(0, 12);
            do_req($urandom_range(0, 15), p, px, py, k, drop, rise,
                   $urandom_range(0, 15), $urandom_range(0, 15));
        end
        wait_drain();

        // Reset while the core is running
        do_req(2, 11, 2, 7, 3, 0, -1, 0, 0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        check("midrst_res_valid", int'(res_valid), 0);
        check("midrst_core_start", int'(core_start), 0);
        check("midrst_core_px", int'(core_px), 0);
        check("midrst_res_status", int'(res_status), 0);
        sbq.delete();
        s0 = starts;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (res_valid || core_start) seen++;
        end
        check("no_activity_after_reset", seen, 0);
        check("no_start_after_reset", starts - s0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
